// File: rtl/dac_write_scheduler_pkg.sv
// Shared types and constants for the dual-DAC write scheduler.
// Optional SIMUL_LDAC_EN adds the simultaneous-update LDAC state.
package dac_write_scheduler_pkg;

    localparam int   DAC_W = 8;
    localparam logic CH_A  = 1'b0;
    localparam logic CH_B  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETUP,
        S_STROBE,
        S_HOLD
`ifdef SIMUL_LDAC_EN
        , S_LDAC
`endif
    } state_t;

    // Phase counters count down to zero, so a phase of n cycles loads n-1.
    function automatic logic [7:0] cyc_init(input int n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/dac_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves on accept.
module rr_arbiter2
    import dac_write_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = (last == CH_B) ? 2'b01 : 2'b10;
    end

    // Reset to B so channel A wins the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= CH_B;
        else if (accept && (|valid))
            last <= grant[1];
    end

endmodule

// File: rtl/dac_write_scheduler.sv
// Arbitrates channels A/B onto the dual-DAC parallel bus and sequences CS/WR/CLR/PD.
// Define SIMUL_LDAC_EN for a shared LDAC pulse after each A-then-B pair.
module dac_write_scheduler
    import dac_write_scheduler_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int WR_LOW_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int LDAC_CYC   = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             reqA_valid,
    input  logic [DAC_W-1:0] reqA_data,
    output logic             reqA_ready,
    input  logic             reqB_valid,
    input  logic [DAC_W-1:0] reqB_data,
    output logic             reqB_ready,
    input  logic             clr_req,
    input  logic             pd_req,
    output logic [DAC_W-1:0] DB,
    output logic             CS,
    output logic             WR,
    output logic             AB,
    output logic             LDAC,
    output logic             CLR,
    output logic             PD,
    output logic             busy
);

`ifdef SIMUL_LDAC_EN
    localparam logic LDAC_RST = 1'b1;
    logic a_written;
`else
    localparam logic LDAC_RST = 1'b0;
`endif

    state_t     state;
    logic [7:0] cnt;
    logic [1:0] grant;
    logic       accept;

    assign accept = (state == S_IDLE) && !clr_req && (reqA_valid || reqB_valid);

    rr_arbiter2 u_arb (
        .clk    (Clk),
        .rst    (Rst),
        .valid  ({reqB_valid, reqA_valid}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            reqA_ready <= 1'b0;
            reqB_ready <= 1'b0;
            DB         <= '0;
            CS         <= 1'b1;
            WR         <= 1'b1;
            AB         <= CH_A;
            LDAC       <= LDAC_RST;
            CLR        <= 1'b1;
            PD         <= 1'b1;
            busy       <= 1'b0;
`ifdef SIMUL_LDAC_EN
            a_written  <= 1'b0;
`endif
        end else begin
            reqA_ready <= 1'b0;
            reqB_ready <= 1'b0;
            PD         <= ~pd_req;
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        CLR   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CLEAR;
`ifdef SIMUL_LDAC_EN
                        a_written <= 1'b0;
`endif
                    end else if (accept) begin
                        reqA_ready <= grant[0];
                        reqB_ready <= grant[1];
                        DB         <= grant[1] ? reqB_data : reqA_data;
                        AB         <= grant[1];
                        CS         <= 1'b0;
                        busy       <= 1'b1;
                        cnt        <= cyc_init(SETUP_CYC);
                        state      <= S_SETUP;
`ifdef SIMUL_LDAC_EN
                        if (!grant[1])
                            a_written <= 1'b1;
`endif
                    end
                end
                S_CLEAR: begin
                    CLR   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        WR    <= 1'b0;
                        cnt   <= cyc_init(WR_LOW_CYC);
                        state <= S_STROBE;
                    end else
                        cnt <= cnt - 8'd1;
                end
                S_STROBE: begin
                    if (cnt == 8'd0) begin
                        WR    <= 1'b1;
                        cnt   <= cyc_init(HOLD_CYC);
                        state <= S_HOLD;
                    end else
                        cnt <= cnt - 8'd1;
                end
                S_HOLD: begin
                    if (cnt == 8'd0) begin
                        CS <= 1'b1;
`ifdef SIMUL_LDAC_EN
                        // A B write that follows an A write latches both outputs together.
                        if (AB == CH_B && a_written) begin
                            LDAC  <= 1'b0;
                            cnt   <= cyc_init(LDAC_CYC);
                            state <= S_LDAC;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= S_IDLE;
`endif
                    end else
                        cnt <= cnt - 8'd1;
                end
`ifdef SIMUL_LDAC_EN
                S_LDAC: begin
                    if (cnt == 8'd0) begin
                        LDAC      <= 1'b1;
                        a_written <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else
                        cnt <= cnt - 8'd1;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed self-checking bench for dac_write_scheduler (default timing 1/2/1/1).
module tb_dac_write_scheduler;

`ifdef SIMUL_LDAC_EN
    localparam logic LDAC_RST = 1'b1;
`else
    localparam logic LDAC_RST = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       reqA_valid = 1'b0, reqB_valid = 1'b0;
    logic [7:0] reqA_data = 8'h00, reqB_data = 8'h00;
    logic       reqA_ready, reqB_ready;
    logic       clr_req = 1'b0, pd_req = 1'b0;
    logic [7:0] DB;
    logic       CS, WR, AB, LDAC, CLR, PD, busy;

    int checks = 0;
    int failures = 0;

    dac_write_scheduler dut (
        .Clk(Clk), .Rst(Rst),
        .reqA_valid(reqA_valid), .reqA_data(reqA_data), .reqA_ready(reqA_ready),
        .reqB_valid(reqB_valid), .reqB_data(reqB_data), .reqB_ready(reqB_ready),
        .clr_req(clr_req), .pd_req(pd_req),
        .DB(DB), .CS(CS), .WR(WR), .AB(AB), .LDAC(LDAC), .CLR(CLR), .PD(PD), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        Rst = 1'b1;
        tick();
        // {CS,WR,AB,CLR,PD,readyA,readyB,busy,LDAC}
        exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LDAC_RST};
        checks++;
        if ({CS, WR, AB, CLR, PD, reqA_ready, reqB_ready, busy, LDAC} !== exp_v) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {CS, WR, AB, CLR, PD, reqA_ready, reqB_ready, busy, LDAC}, exp_v);
        end
        checks++;
        if (DB !== 8'h00) begin
            failures++;
            $display("FAIL reset_db got=%h exp=00", DB);
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_single_a();
        logic [4:0] exp_v;
        reqA_valid = 1'b1;
        reqA_data  = 8'h5A;
        tick();
        reqA_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            // {CS,WR,readyA,readyB,busy}
            exp_v = {(c == 5), !(c == 2 || c == 3), (c == 1), 1'b0, (c <= 4)};
            checks++;
            if ({CS, WR, reqA_ready, reqB_ready, busy} !== exp_v) begin
                failures++;
                $display("FAIL single_a_ctrl cyc=%0d got=%b exp=%b", c, {CS, WR, reqA_ready, reqB_ready, busy}, exp_v);
            end
            checks++;
            if (DB !== 8'h5A || AB !== 1'b0 || LDAC !== LDAC_RST) begin
                failures++;
                $display("FAIL single_a_bus cyc=%0d got DB=%h AB=%b LDAC=%b exp DB=5a AB=0 LDAC=%b", c, DB, AB, LDAC, LDAC_RST);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ch;
        logic prev_cs;
        int   grants;
        reqA_data  = 8'h11;
        reqB_data  = 8'h22;
        reqA_valid = 1'b1;
        reqB_valid = 1'b1;
        exp_ch  = 1'b1;  // A was served last
        grants  = 0;
        prev_cs = CS;
        for (int i = 0; i < 80 && grants < 4; i++) begin
            tick();
            if (reqA_ready || reqB_ready) begin
                checks++;
                if ((reqA_ready && reqB_ready) || AB !== exp_ch || reqB_ready !== exp_ch ||
                    DB !== (exp_ch ? 8'h22 : 8'h11)) begin
                    failures++;
                    $display("FAIL b2b_grant n=%0d got rA=%b rB=%b AB=%b DB=%h exp_ch=%b", grants, reqA_ready, reqB_ready, AB, DB, exp_ch);
                end
                checks++;
                if (prev_cs !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_cs_gap n=%0d prev_cs=%b exp=1", grants, prev_cs);
                end
                exp_ch = ~exp_ch;
                grants++;
                if (grants == 4) begin
                    reqA_valid = 1'b0;
                    reqB_valid = 1'b0;
                end
            end
            prev_cs = CS;
        end
        checks++;
        if (grants != 4) begin
            failures++;
            $display("FAIL b2b_timeout grants=%0d exp=4", grants);
        end
        reqA_valid = 1'b0;
        reqB_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_clear();
        clr_req    = 1'b1;
        reqA_valid = 1'b1;
        reqA_data  = 8'h33;
        tick();
        clr_req = 1'b0;
        checks++;
        if (CLR !== 1'b0 || busy !== 1'b1 || reqA_ready !== 1'b0 || CS !== 1'b1) begin
            failures++;
            $display("FAIL clear_pulse got CLR=%b busy=%b rA=%b CS=%b exp 0 1 0 1", CLR, busy, reqA_ready, CS);
        end
        tick();
        checks++;
        if (CLR !== 1'b1 || reqA_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_end got CLR=%b rA=%b exp 1 0", CLR, reqA_ready);
        end
        tick();
        reqA_valid = 1'b0;
        checks++;
        if (reqA_ready !== 1'b1 || CS !== 1'b0 || DB !== 8'h33 || AB !== 1'b0 || CLR !== 1'b1) begin
            failures++;
            $display("FAIL clear_then_a got rA=%b CS=%b DB=%h AB=%b CLR=%b exp 1 0 33 0 1", reqA_ready, CS, DB, AB, CLR);
        end
        repeat (5) tick();
    endtask

    task automatic test_pd();
        logic [1:0] exp_v;
        reqA_valid = 1'b1;
        reqA_data  = 8'h9C;
        tick();
        reqA_valid = 1'b0;
        pd_req     = 1'b1;
        checks++;
        if (PD !== 1'b1 || CS !== 1'b0) begin
            failures++;
            $display("FAIL pd_before got PD=%b CS=%b exp 1 0", PD, CS);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            exp_v = {(c == 5), !(c == 2 || c == 3)};
            checks++;
            if ({CS, WR} !== exp_v || PD !== 1'b0 || DB !== 8'h9C) begin
                failures++;
                $display("FAIL pd_write cyc=%0d got CS/WR=%b PD=%b DB=%h exp %b 0 9c", c, {CS, WR}, PD, DB, exp_v);
            end
        end
        pd_req = 1'b0;
        tick();
        checks++;
        if (PD !== 1'b1) begin
            failures++;
            $display("FAIL pd_release got=%b exp=1", PD);
        end
    endtask

    task automatic test_rst_mid();
        reqA_valid = 1'b1;
        reqA_data  = 8'h77;
        tick();
        reqA_valid = 1'b0;
        tick();
        checks++;
        if (WR !== 1'b0 || CS !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_strobe got WR=%b CS=%b exp 0 0", WR, CS);
        end
        #1;
        Rst = 1'b1;
        #1;
        checks++;
        if (WR !== 1'b1 || CS !== 1'b1 || DB !== 8'h00 || busy !== 1'b0 || AB !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async got WR=%b CS=%b DB=%h busy=%b AB=%b exp 1 1 00 0 0", WR, CS, DB, busy, AB);
        end
        tick();
        Rst = 1'b0;
        tick();
        reqA_data  = 8'h11;
        reqB_data  = 8'h22;
        reqA_valid = 1'b1;
        reqB_valid = 1'b1;
        tick();
        reqA_valid = 1'b0;
        reqB_valid = 1'b0;
        checks++;
        if (reqA_ready !== 1'b1 || reqB_ready !== 1'b0 || AB !== 1'b0 || DB !== 8'h11) begin
            failures++;
            $display("FAIL rst_mid_first_a got rA=%b rB=%b AB=%b DB=%h exp 1 0 0 11", reqA_ready, reqB_ready, AB, DB);
        end
        repeat (5) tick();
    endtask

`ifdef SIMUL_LDAC_EN
    task automatic test_ldac();
        logic exp_l;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();
        reqA_valid = 1'b1;
        reqA_data  = 8'h80;
        tick();
        reqA_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            checks++;
            if (LDAC !== 1'b1) begin
                failures++;
                $display("FAIL ldac_a cyc=%0d got=%b exp=1", c, LDAC);
            end
        end
        reqB_valid = 1'b1;
        reqB_data  = 8'h40;
        tick();
        reqB_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            exp_l = (c != 5);
            checks++;
            if (LDAC !== exp_l || busy !== (c <= 5)) begin
                failures++;
                $display("FAIL ldac_b cyc=%0d got LDAC=%b busy=%b exp %b %b", c, LDAC, busy, exp_l, (c <= 5));
            end
        end
        reqB_valid = 1'b1;
        reqB_data  = 8'h41;
        tick();
        reqB_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            checks++;
            if (LDAC !== 1'b1) begin
                failures++;
                $display("FAIL ldac_b_alone cyc=%0d got=%b exp=1", c, LDAC);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a();
        test_back_to_back();
        test_clear();
        test_pd();
        test_rst_mid();
`ifdef SIMUL_LDAC_EN
        test_ldac();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
